alu_op_queue: RTL and testbench

Operand/opcode buffer sitting directly upstream of the ALU in the CPU datapath. Accepts decoded ALU operations (4-bit opcode, two REG_WIDTH operands, carry-in) from the decode stage over a valid/ready handshake and presents them in order to the ALU input ports. It decouples decode from ALU stalls, exposes occupancy, and records illegal pushes.

---
 rtl/alu_op_queue_if.sv | 36 +++
 rtl/alu_op_queue.sv | 127 ++++++++++++
 tb/tb_alu_op_queue.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_queue_if.sv
// ---------------------------------------------------------------------------
// alu_op_queue_if
// Purpose : groups the decode-side (push) and ALU-side (pop) valid/ready
//           handshakes of the ALU operation queue into one bundle.
// Signals : in_valid_i/in_ready_o, in_instr_i, in_a_i, in_b_i, in_cin_i
//           out_valid_o/out_ready_i, out_instr_o, out_a_o, out_b_o, out_cin_o
// Modports: slave  - the queue itself (accepts pushes, presents the head)
//           master - the surrounding datapath (decode + ALU)
// ---------------------------------------------------------------------------
interface alu_op_queue_if #(
  parameter int REG_WIDTH = 16
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [3:0]           in_instr_i;
  logic [REG_WIDTH-1:0] in_a_i;
  logic [REG_WIDTH-1:0] in_b_i;
  logic                 in_cin_i;

  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [3:0]           out_instr_o;
  logic [REG_WIDTH-1:0] out_a_o;
  logic [REG_WIDTH-1:0] out_b_o;
  logic                 out_cin_o;

  modport slave (
    input  in_valid_i, in_instr_i, in_a_i, in_b_i, in_cin_i, out_ready_i,
    output in_ready_o, out_valid_o, out_instr_o, out_a_o, out_b_o, out_cin_o
  );

  modport master (
    output in_valid_i, in_instr_i, in_a_i, in_b_i, in_cin_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_instr_o, out_a_o, out_b_o, out_cin_o
  );
endinterface

// File: rtl/alu_op_queue.sv
// ---------------------------------------------------------------------------
// alu_op_queue
// Purpose : in-order buffer of decoded ALU operations between decode and the
//           ALU. Decouples decode from ALU stalls, reports occupancy and
//           records (sticky) pushes that were refused.
// Ports   : clk        - rising-edge clock
//           reset      - asynchronous, active-high reset
//           bus        - alu_op_queue_if.slave (push and pop handshakes)
//           flush_i    - discard every entry on the next edge
//           count_o    - number of resident entries
//           full_o     - count_o == DEPTH
//           empty_o    - count_o == 0
//           push_err_o - sticky: valid presented while not ready (no flush)
// Options : ALU_OP_QUEUE_BYPASS_EN - when defined, an operation offered to an
//           empty queue while the ALU is ready passes straight through to the
//           outputs in the same cycle without being stored.
// ---------------------------------------------------------------------------
module alu_op_queue #(
  parameter int REG_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  alu_op_queue_if.slave              bus,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       push_err_o
);

  localparam int PtrW   = $clog2(DEPTH);
  localparam int CntW   = $clog2(DEPTH + 1);
  localparam int EntryW = 4 + 2 * REG_WIDTH + 1;

  logic [EntryW-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wrPtr;
  logic [PtrW-1:0]   r_rdPtr;
  logic [CntW-1:0]   r_count;
  logic              r_pushErr;

  logic              w_full;
  logic              w_empty;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic [EntryW-1:0] w_inEntry;
  logic [EntryW-1:0] w_headEntry;

  assign w_full      = (r_count == CntW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_inEntry   = {bus.in_instr_i, bus.in_a_i, bus.in_b_i, bus.in_cin_i};
  assign w_headEntry = r_mem[r_rdPtr];

`ifdef ALU_OP_QUEUE_BYPASS_EN
  // An empty queue with a ready ALU hands the operation over directly.
  assign w_bypass = w_empty & bus.in_valid_i & bus.out_ready_i;
`else
  assign w_bypass = 1'b0;
`endif

  // Ready depends only on full, so a full queue refuses a push even when the
  // head is popped in the same cycle. Flush wins over both push and pop.
  assign w_push = bus.in_valid_i & ~w_full & ~w_bypass & ~flush_i;
  assign w_pop  = ~w_empty & bus.out_ready_i & ~flush_i;

  // Storage: zeroed on reset so the head reads as zero right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wrPtr] <= w_inEntry;
    end
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // naturally from DEPTH-1 back to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PtrW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PtrW'(1);
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  // Sticky refused-push flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pushErr <= 1'b0;
    end else if (bus.in_valid_i & w_full & ~flush_i) begin
      r_pushErr <= 1'b1;
    end
  end

  // Head presentation toward the ALU (or the bypassed input when enabled).
  always_comb begin
    bus.out_valid_o = ~w_empty;
    {bus.out_instr_o, bus.out_a_o, bus.out_b_o, bus.out_cin_o} = w_headEntry;
`ifdef ALU_OP_QUEUE_BYPASS_EN
    if (w_bypass) begin
      bus.out_valid_o = 1'b1;
      {bus.out_instr_o, bus.out_a_o, bus.out_b_o, bus.out_cin_o} = w_inEntry;
    end
`endif
  end

  assign bus.in_ready_o = ~w_full;
  assign count_o        = r_count;
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign push_err_o     = r_pushErr;

endmodule

// File: tb/tb_alu_op_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_op_queue
// Purpose : self-checking bench for alu_op_queue. A behavioural model keeps
//           the expected queue contents as a plain SV queue; every cycle the
//           monitor compares the DUT's status and head against it, then
//           applies the cycle's push/pop/flush to the model.
// Options : honours ALU_OP_QUEUE_BYPASS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_alu_op_queue;

  localparam int REG_WIDTH = 16;
  localparam int DEPTH     = 4;
  localparam int CntW      = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]           instr;
    logic [REG_WIDTH-1:0] a;
    logic [REG_WIDTH-1:0] b;
    logic                 cin;
  } op_t;

  logic            clk   = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic [CntW-1:0] count;
  logic            full;
  logic            empty;
  logic            pushErr;

  int total = 0;
  int bad   = 0;

  op_t  sb[$];
  logic errModel = 1'b0;

`ifdef ALU_OP_QUEUE_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  alu_op_queue_if #(.REG_WIDTH(REG_WIDTH)) bus ();

  alu_op_queue #(
    .REG_WIDTH(REG_WIDTH),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .flush_i   (flush),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty),
    .push_err_o(pushErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t randOp();
    op_t r;
    r.instr = 4'($urandom);
    r.a     = REG_WIDTH'($urandom);
    r.b     = REG_WIDTH'($urandom);
    r.cin   = 1'($urandom);
    return r;
  endfunction

  function automatic op_t inputOp();
    op_t r;
    r.instr = bus.in_instr_i;
    r.a     = bus.in_a_i;
    r.b     = bus.in_b_i;
    r.cin   = bus.in_cin_i;
    return r;
  endfunction

  // Drive one cycle of inputs (called just after a rising edge) and return
  // just after the next rising edge.
  task automatic applyStimulus(input logic v, input op_t op, input logic ordy, input logic fl);
    bus.in_valid_i  = v;
    bus.in_instr_i  = op.instr;
    bus.in_a_i      = op.a;
    bus.in_b_i      = op.b;
    bus.in_cin_i    = op.cin;
    bus.out_ready_i = ordy;
    flush           = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_count"},     count, 0);
    checkOutput({tag, "_empty"},     empty, 1);
    checkOutput({tag, "_full"},      full, 0);
    checkOutput({tag, "_in_ready"},  bus.in_ready_o, 1);
    checkOutput({tag, "_out_valid"}, bus.out_valid_o, 0);
    checkOutput({tag, "_out_fields"},
                {bus.out_instr_o, bus.out_a_o, bus.out_b_o, bus.out_cin_o}, 0);
    checkOutput({tag, "_push_err"},  pushErr, 0);
  endtask

  // Monitor and reference model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin : monitor
    int occ;
    bit byp;
    if (reset) begin
      sb.delete();
      errModel = 1'b0;
    end else begin
      occ = sb.size();
      byp = BypassEn && (occ == 0) && bus.in_valid_i && bus.out_ready_i;
      checkOutput("count",     count, occ);
      checkOutput("empty",     empty, occ == 0);
      checkOutput("full",      full, occ == DEPTH);
      checkOutput("in_ready",  bus.in_ready_o, occ < DEPTH);
      checkOutput("out_valid", bus.out_valid_o, (occ > 0) || byp);
      checkOutput("push_err",  pushErr, errModel);
      if (byp) begin
        checkOutput("bypass_head",
                    {bus.out_instr_o, bus.out_a_o, bus.out_b_o, bus.out_cin_o}, inputOp());
      end else if (occ > 0) begin
        checkOutput("head",
                    {bus.out_instr_o, bus.out_a_o, bus.out_b_o, bus.out_cin_o}, sb[0]);
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (bus.in_valid_i && occ == DEPTH) errModel = 1'b1;
        if (occ > 0 && bus.out_ready_i) void'(sb.pop_front());
        if (bus.in_valid_i && occ < DEPTH && !byp) sb.push_back(inputOp());
      end
    end
  end

  initial begin : stimulus
    op_t first;
    bus.in_valid_i  = 1'b0;
    bus.in_instr_i  = '0;
    bus.in_a_i      = '0;
    bus.in_b_i      = '0;
    bus.in_cin_i    = 1'b0;
    bus.out_ready_i = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Single push, held at the head.
    first = '{instr: 4'h3, a: 16'h1234, b: 16'h00FF, cin: 1'b1};
    applyStimulus(1'b1, first, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t1_out_valid", bus.out_valid_o, 1);
    checkOutput("t1_fields",
                {bus.out_instr_o, bus.out_a_o, bus.out_b_o, bus.out_cin_o}, first);
    checkOutput("t1_count", count, 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Fill, overflow attempt, drain in order.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, randOp(), 1'b0, 1'b0);
    checkOutput("fill_full",     full, 1);
    checkOutput("fill_in_ready", bus.in_ready_o, 0);
    applyStimulus(1'b1, randOp(), 1'b0, 1'b0);
    checkOutput("overflow_err", pushErr, 1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("drain_empty", empty, 1);
    checkOutput("drain_err_sticky", pushErr, 1);

    // Steady state with two resident entries while pointers wrap.
    applyStimulus(1'b1, randOp(), 1'b0, 1'b0);
    applyStimulus(1'b1, randOp(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, randOp(), 1'b1, 1'b0);
    checkOutput("steady_count", count, 2);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Full queue: push and pop together, push refused.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, randOp(), 1'b0, 1'b0);
    applyStimulus(1'b1, randOp(), 1'b1, 1'b0);
    checkOutput("full_pushpop_count", count, DEPTH - 1);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Flush with a simultaneous push.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randOp(), 1'b0, 1'b0);
    applyStimulus(1'b1, randOp(), 1'b0, 1'b1);
    checkOutput("flush_count", count, 0);
    checkOutput("flush_empty", empty, 1);
    checkOutput("flush_err_kept", pushErr, 1);

    // Same-cycle behaviour on an empty queue with a ready ALU.
    bus.in_valid_i  = 1'b1;
    bus.in_instr_i  = 4'h7;
    bus.out_ready_i = 1'b1;
    flush           = 1'b0;
    #1;
    checkOutput("zero_lat_valid", bus.out_valid_o, BypassEn);
    if (BypassEn) checkOutput("zero_lat_instr", bus.out_instr_o, 4'h7);
    checkOutput("zero_lat_count", count, 0);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    #1;
    checkOutput("next_cycle_valid", bus.out_valid_o, !BypassEn);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Randomised traffic with alternating ALU-stall phases.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), randOp(),
                    ((i / 25) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                        : ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 31) == 0);
    end

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randOp(), 1'b0, 1'b0);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkResetValues("mid_reset");
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) applyStimulus(1'($urandom_range(0, 1)), randOp(),
                                               1'($urandom_range(0, 1)), 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
